// File: rtl/alu_op_sequencer_if.sv
// Request/result bundle between instruction control and the ALU op sequencer.
interface alu_op_sequencer_if #(
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
);
   logic              req_valid;
   logic              req_ready;
   logic [3:0]        req_func;
   logic [DATA_W-1:0] req_a;
   logic [DATA_W-1:0] req_b;
   logic [6:0]        en;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;
   logic              done;
   logic [3:0]        res_func;
   logic              illegal;
   logic              div_zero;
   logic              busy;
   logic [CNT_W-1:0]  op_count;

   // Instruction control side
   modport master (
      output req_valid, req_func, req_a, req_b,
      input  req_ready, en, op_a, op_b, done, res_func, illegal, div_zero, busy, op_count
   );

   // Sequencer side
   modport slave (
      input  req_valid, req_func, req_a, req_b,
      output req_ready, en, op_a, op_b, done, res_func, illegal, div_zero, busy, op_count
   );
endinterface

// File: rtl/alu_op_sequencer.sv
// ALU op sequencer: accepts one request, holds the decoded one-hot unit
// enable for a short or long window, then pulses done with status flags.
module alu_op_sequencer #(
   parameter int DATA_W       = 8,
   parameter int SHORT_CYCLES = 1,
   parameter int LONG_CYCLES  = 8,
   parameter int CNT_W        = 8
) (
   input  logic                clk,
   input  logic                rst,
   alu_op_sequencer_if.slave   bus
);

   localparam int MAX_CYC = (LONG_CYCLES > SHORT_CYCLES) ? LONG_CYCLES : SHORT_CYCLES;
   localparam int HOLD_W  = $clog2(MAX_CYC + 1);

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t            state;
   logic [HOLD_W-1:0] hold;
   logic [3:0]        func_q;
   logic [DATA_W-1:0] a_q;
   logic [DATA_W-1:0] b_q;
   logic [6:0]        en_q;
   logic              done_q;
   logic [3:0]        res_func_q;
   logic              illegal_q;
   logic              div_zero_q;
   logic [CNT_W-1:0]  op_count_q;

   // Function code to one-hot unit enable; zero means unsupported.
   function automatic logic [6:0] decode(input logic [3:0] f);
      case (f)
         4'b0011: decode = 7'b0100000; // add
         4'b0100: decode = 7'b0010000; // sub
         4'b0101: decode = 7'b1000000; // xor
         4'b0110: decode = 7'b0000100; // or
         4'b0111: decode = 7'b0001000; // and
         4'b1000: decode = 7'b0000010; // div
         4'b1001: decode = 7'b0000001; // mod
         default: decode = 7'b0000000;
      endcase
   endfunction

   function automatic logic is_long(input logic [3:0] f);
      is_long = (f == 4'b1000) || (f == 4'b1001);
   endfunction

   // Sequencer FSM; every output is a register or a decode of state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         hold       <= '0;
         func_q     <= '0;
         a_q        <= '0;
         b_q        <= '0;
         en_q       <= '0;
         done_q     <= 1'b0;
         res_func_q <= '0;
         illegal_q  <= 1'b0;
         div_zero_q <= 1'b0;
         op_count_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.req_valid) begin
                  func_q <= bus.req_func;
                  a_q    <= bus.req_a;
                  b_q    <= bus.req_b;
                  if (|decode(bus.req_func)) begin
                     state <= EXEC;
                     en_q  <= decode(bus.req_func);
                     hold  <= is_long(bus.req_func) ? HOLD_W'(LONG_CYCLES)
                                                    : HOLD_W'(SHORT_CYCLES);
                  end else begin
                     // Unsupported codes skip the enable window entirely.
                     state      <= DONE;
                     done_q     <= 1'b1;
                     illegal_q  <= 1'b1;
                     res_func_q <= bus.req_func;
                  end
               end
            end
            EXEC: begin
               if (hold == HOLD_W'(1)) begin
                  state      <= DONE;
                  en_q       <= '0;
                  done_q     <= 1'b1;
                  res_func_q <= func_q;
                  div_zero_q <= is_long(func_q) && (b_q == '0);
               end else begin
                  hold <= hold - HOLD_W'(1);
               end
            end
            DONE: begin
               state      <= IDLE;
               done_q     <= 1'b0;
               illegal_q  <= 1'b0;
               div_zero_q <= 1'b0;
               // Divide-by-zero still counts as a completed legal op.
               if (!illegal_q) op_count_q <= op_count_q + CNT_W'(1);
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.req_ready = (state == IDLE);
   assign bus.busy      = (state != IDLE);
   assign bus.en        = en_q;
   assign bus.op_a      = a_q;
   assign bus.op_b      = b_q;
   assign bus.done      = done_q;
   assign bus.res_func  = res_func_q;
   assign bus.illegal   = illegal_q;
   assign bus.div_zero  = div_zero_q;
   assign bus.op_count  = op_count_q;

endmodule
